// File: rtl/jtag_pkg.sv
// Shared JTAG opcodes, defaults and the instruction-to-select decode.
package jtag_pkg;

  localparam int unsigned JTAG_IR_WIDTH_DEFAULT = 4;
  localparam logic [31:0] JTAG_IDCODE_DEFAULT   = 32'h1000_0001;

  // BYPASS is all-ones at whatever IR width is in use, so it has no fixed constant.
  localparam int unsigned OPC_EXTEST = 0;
  localparam int unsigned OPC_SAMPLE = 1;
  localparam int unsigned OPC_IDCODE = 2;

  typedef enum logic [1:0] {
    INSTR_EXTEST,
    INSTR_SAMPLE,
    INSTR_IDCODE,
    INSTR_BYPASS
  } instr_e;

  typedef struct packed {
    logic extest;
    logic sample;
    logic idcode;
    logic bypass;
  } sel_t;

  function automatic sel_t instr_to_sel(input instr_e instr);
    sel_t sel;
    sel = '0;
    unique case (instr)
      INSTR_EXTEST: sel.extest = 1'b1;
      INSTR_SAMPLE: sel.sample = 1'b1;
      INSTR_IDCODE: sel.idcode = 1'b1;
      default:      sel.bypass = 1'b1;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_id_reg.sv
// 32-bit IDCODE data register: parallel capture of the device ID, LSB-first shift-out.
module jtag_id_reg
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = JTAG_IDCODE_DEFAULT
) (
  input  logic TCK,
  input  logic TRST,
  input  logic TDI,
  input  logic capture,
  input  logic shift,
  output logic tdo
);

  logic [31:0] id_d;
  logic [31:0] id_q;

  always_comb begin
    id_d = id_q;
    if (capture) begin
      id_d = IDCODE_VALUE;
    end else if (shift) begin
      id_d = {TDI, id_q[31:1]};
    end
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      id_q <= IDCODE_VALUE;
    end else begin
      id_q <= id_d;
    end
  end

  assign tdo = id_q[0];

endmodule

// File: rtl/jtag_ir_decoder.sv
// JTAG instruction register, decode, bypass/IDCODE data registers and TDO mux.
// Define JTAG_IDCODE_EN to include the IDCODE register/opcode (reset instruction becomes IDCODE).
module jtag_ir_decoder
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH     = JTAG_IR_WIDTH_DEFAULT,
  parameter logic [31:0] IDCODE_VALUE = JTAG_IDCODE_DEFAULT
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TDI,
  input  logic                clockir,
  input  logic                shiftir,
  input  logic                updateir,
  input  logic                clockdr,
  input  logic                shiftdr,
  input  logic                select,
  input  logic                bsr_tdo,
  output logic                TDO,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                extest_sel,
  output logic                sample_sel,
  output logic                idcode_sel,
  output logic                bypass_sel
);

  if (IR_WIDTH < 2) begin : g_ir_width_check
    $error("jtag_ir_decoder: IR_WIDTH must be at least 2");
  end
  if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_check
    $error("jtag_ir_decoder: IDCODE_VALUE bit 0 must be 1");
  end

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RST_IR    = IR_WIDTH'(OPC_IDCODE);
  localparam instr_e              RST_INSTR = INSTR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RST_IR    = '1;
  localparam instr_e              RST_INSTR = INSTR_BYPASS;
`endif

  function automatic instr_e classify(input logic [IR_WIDTH-1:0] ir);
    if (ir == IR_WIDTH'(OPC_EXTEST)) return INSTR_EXTEST;
    if (ir == IR_WIDTH'(OPC_SAMPLE)) return INSTR_SAMPLE;
`ifdef JTAG_IDCODE_EN
    if (ir == IR_WIDTH'(OPC_IDCODE)) return INSTR_IDCODE;
`endif
    return INSTR_BYPASS;
  endfunction

  logic [IR_WIDTH-1:0] ir_shift_d, ir_shift_q;
  logic [IR_WIDTH-1:0] ir_out_d,   ir_out_q;
  sel_t                sel_d,      sel_q;
  logic                bypass_d,   bypass_q;
  logic                id_tdo;

  always_comb begin
    ir_shift_d = ir_shift_q;
    if (clockir) begin
      if (shiftir) begin
        ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
      end else begin
        ir_shift_d = IR_WIDTH'(1);
      end
    end
  end

  // Update samples the pre-edge shift register, so a simultaneous shift does not leak in.
  always_comb begin
    ir_out_d = ir_out_q;
    sel_d    = sel_q;
    if (updateir) begin
      ir_out_d = ir_shift_q;
      sel_d    = instr_to_sel(classify(ir_shift_q));
    end
  end

  always_comb begin
    bypass_d = bypass_q;
    if (clockdr) begin
      bypass_d = shiftdr ? TDI : 1'b0;
    end
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_shift_q <= '0;
      ir_out_q   <= RST_IR;
      sel_q      <= instr_to_sel(RST_INSTR);
      bypass_q   <= 1'b0;
    end else begin
      ir_shift_q <= ir_shift_d;
      ir_out_q   <= ir_out_d;
      sel_q      <= sel_d;
      bypass_q   <= bypass_d;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic id_capture;
  logic id_shift;

  assign id_capture = clockdr & ~shiftdr & sel_q.idcode;
  assign id_shift   = clockdr &  shiftdr & sel_q.idcode;

  jtag_id_reg #(
    .IDCODE_VALUE(IDCODE_VALUE)
  ) u_id_reg (
    .TCK    (TCK),
    .TRST   (TRST),
    .TDI    (TDI),
    .capture(id_capture),
    .shift  (id_shift),
    .tdo    (id_tdo)
  );

  assign idcode_sel = sel_q.idcode;
`else
  assign id_tdo     = 1'b0;
  assign idcode_sel = 1'b0;
`endif

  always_comb begin
    if (select) begin
      TDO = ir_shift_q[0];
    end else if (sel_q.extest | sel_q.sample) begin
      TDO = bsr_tdo;
    end else if (sel_q.idcode) begin
      TDO = id_tdo;
    end else begin
      TDO = bypass_q;
    end
  end

  assign tdo_en     = (clockir & shiftir) | (clockdr & shiftdr);
  assign ir_out     = ir_out_q;
  assign extest_sel = sel_q.extest;
  assign sample_sel = sel_q.sample;
  assign bypass_sel = sel_q.bypass;

endmodule

// File: tb/tb_jtag_ir_decoder.sv
// Scoreboard bench for jtag_ir_decoder; expectations adapt to JTAG_IDCODE_EN.
module tb_jtag_ir_decoder;

  localparam int unsigned IRW = 4;
  localparam logic [31:0] IDV = 32'h4BA0_0477;

  // Select vectors are packed as {extest, sample, idcode, bypass}.
  localparam logic [3:0] SEL_EXTEST = 4'b1000;
  localparam logic [3:0] SEL_SAMPLE = 4'b0100;
  localparam logic [3:0] SEL_IDCODE = 4'b0010;
  localparam logic [3:0] SEL_BYPASS = 4'b0001;

`ifdef JTAG_IDCODE_EN
  localparam logic [IRW-1:0] RST_IR  = 4'b0010;
  localparam logic [3:0]     RST_SEL = SEL_IDCODE;
  localparam logic           RST_TDO = 1'b1;   // id[0] of the ID value
`else
  localparam logic [IRW-1:0] RST_IR  = 4'b1111;
  localparam logic [3:0]     RST_SEL = SEL_BYPASS;
  localparam logic           RST_TDO = 1'b0;   // bypass flop
`endif

  logic           TCK = 1'b0;
  logic           TRST, TDI, clockir, shiftir, updateir, clockdr, shiftdr, select, bsr_tdo;
  logic           TDO, tdo_en;
  logic [IRW-1:0] ir_out;
  logic           extest_sel, sample_sel, idcode_sel, bypass_sel;

  jtag_ir_decoder #(
    .IR_WIDTH    (IRW),
    .IDCODE_VALUE(IDV)
  ) dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .TDI       (TDI),
    .clockir   (clockir),
    .shiftir   (shiftir),
    .updateir  (updateir),
    .clockdr   (clockdr),
    .shiftdr   (shiftdr),
    .select    (select),
    .bsr_tdo   (bsr_tdo),
    .TDO       (TDO),
    .tdo_en    (tdo_en),
    .ir_out    (ir_out),
    .extest_sel(extest_sel),
    .sample_sel(sample_sel),
    .idcode_sel(idcode_sel),
    .bypass_sel(bypass_sel)
  );

  always #5 TCK = ~TCK;

  typedef enum {OBS_TDO, OBS_TDO_EN, OBS_IR, OBS_SEL} obs_e;
  typedef struct {
    obs_e        kind;
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input obs_e kind, input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.kind = kind;
    it.tag  = tag;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  function automatic logic [31:0] observe(input obs_e kind);
    case (kind)
      OBS_TDO:    return 32'(TDO);
      OBS_TDO_EN: return 32'(tdo_en);
      OBS_IR:     return 32'(ir_out);
      default:    return 32'({extest_sel, sample_sel, idcode_sel, bypass_sel});
    endcase
  endfunction

  task automatic sb_drain;
    sb_item_t it;
    #2;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check_eq(it.tag, observe(it.kind), it.exp);
    end
  endtask

  task automatic drive(input logic ci, input logic si, input logic ui,
                       input logic cd, input logic sd, input logic tdi);
    clockir  = ci;
    shiftir  = si;
    updateir = ui;
    clockdr  = cd;
    shiftdr  = sd;
    TDI      = tdi;
  endtask

  task automatic tick;
    @(posedge TCK);
    #1;
  endtask

  task automatic load_ir(input logic [IRW-1:0] val);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    for (int unsigned i = 0; i < IRW; i++) begin
      drive(1, 1, 0, 0, 0, val[i]);
      tick();
    end
    drive(0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  v;
    logic [3:0]  ir_tdo_seq;
    logic [2:0]  byp_tdi;
    logic [5:0]  long_seq;
    logic [31:0] idv;

    TRST = 1'b1; select = 1'b1; bsr_tdo = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // tdo_en is purely combinational; sweep all enable combinations while held in reset
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      clockir = v[3]; shiftir = v[2]; clockdr = v[1]; shiftdr = v[0];
      expect_out(OBS_TDO_EN, "tdo_en_sweep", 32'((v[3] & v[2]) | (v[1] & v[0])));
      sb_drain();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    TRST = 1'b0;

    // Reset state
    expect_out(OBS_IR, "rst_ir", 32'(RST_IR));
    expect_out(OBS_SEL, "rst_sel", 32'(RST_SEL));
    expect_out(OBS_TDO, "rst_ir_shift0", 32'(1'b0));
    sb_drain();
    select = 1'b0;
    expect_out(OBS_TDO, "rst_dr_tdo", 32'(RST_TDO));
    sb_drain();

    // IR capture then four zero shifts: the captured ...0001 comes out LSB first
    select = 1'b1;
    ir_tdo_seq = 4'b0001;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    for (int unsigned i = 0; i < IRW; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      expect_out(OBS_TDO, "ir_shift_tdo", 32'(ir_tdo_seq[i]));
      expect_out(OBS_TDO_EN, "ir_shift_en", 32'(1'b1));
      sb_drain();
      tick();
    end
    drive(0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_out(OBS_IR, "extest_ir", 32'(0));
    expect_out(OBS_SEL, "extest_sel", 32'(SEL_EXTEST));
    sb_drain();
    select = 1'b0; bsr_tdo = 1'b1;
    expect_out(OBS_TDO, "extest_bsr1", 32'(1'b1));
    sb_drain();
    bsr_tdo = 1'b0;
    expect_out(OBS_TDO, "extest_bsr0", 32'(1'b0));
    sb_drain();

    // clockir low holds ir_shift even with shiftir high
    select = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    tick();
    tick();
    expect_out(OBS_TDO, "ir_hold", 32'(1'b1));
    sb_drain();

    // Update together with a shift latches the pre-edge value (0001 = SAMPLE)
    drive(1, 1, 1, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_out(OBS_IR, "upd_shift_ir", 32'(1));
    expect_out(OBS_SEL, "upd_shift_sel", 32'(SEL_SAMPLE));
    expect_out(OBS_TDO, "upd_shift_irlsb", 32'(1'b0));
    sb_drain();
    select = 1'b0; bsr_tdo = 1'b1;
    expect_out(OBS_TDO, "sample_bsr", 32'(1'b1));
    sb_drain();
    bsr_tdo = 1'b0;

    // BYPASS: one-cycle delay from TDI to TDO
    load_ir(4'b1111);
    expect_out(OBS_IR, "bypass_ir", 32'(4'hF));
    expect_out(OBS_SEL, "bypass_sel", 32'(SEL_BYPASS));
    sb_drain();
    select = 1'b0;
    byp_tdi = 3'b101;
    drive(0, 0, 0, 1, 0, 0);
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1, byp_tdi[i]);
      expect_out(OBS_TDO, "bypass_tdo", (i == 0) ? 32'(1'b0) : 32'(byp_tdi[i-1]));
      expect_out(OBS_TDO_EN, "bypass_en", 32'(1'b1));
      sb_drain();
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    expect_out(OBS_TDO, "bypass_tdo_last", 32'(byp_tdi[2]));
    sb_drain();

    // IDCODE opcode
    load_ir(4'b0010);
    expect_out(OBS_IR, "idcode_ir", 32'(4'h2));
`ifdef JTAG_IDCODE_EN
    expect_out(OBS_SEL, "idcode_sel", 32'(SEL_IDCODE));
    sb_drain();
    idv = IDV;
    drive(0, 0, 0, 1, 0, 0);
    tick();
    for (int unsigned i = 0; i < 32; i++) begin
      drive(0, 0, 0, 1, 1, 0);
      expect_out(OBS_TDO, "idcode_tdo", 32'(idv[i]));
      sb_drain();
      tick();
    end
`else
    expect_out(OBS_SEL, "idcode_as_bypass", 32'(SEL_BYPASS));
    sb_drain();
    drive(0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 1, 1, 1);
    expect_out(OBS_TDO, "idcode_byp_tdo0", 32'(1'b0));
    sb_drain();
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_out(OBS_TDO, "idcode_byp_tdo1", 32'(1'b1));
    sb_drain();
`endif
    drive(0, 0, 0, 0, 0, 0);

    // Unassigned codes decode as BYPASS
    load_ir(4'b0101);
    expect_out(OBS_IR, "opc5_ir", 32'(4'h5));
    expect_out(OBS_SEL, "opc5_sel", 32'(SEL_BYPASS));
    sb_drain();
    load_ir(4'b0111);
    expect_out(OBS_SEL, "opc7_sel", 32'(SEL_BYPASS));
    sb_drain();

    // Over-long shift keeps the last IR_WIDTH bits: 1,1,1,0,0,0 leaves 0001
    long_seq = 6'b000111;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    for (int unsigned i = 0; i < 6; i++) begin
      drive(1, 1, 0, 0, 0, long_seq[i]);
      tick();
    end
    drive(0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_out(OBS_IR, "long_shift_ir", 32'(1));
    expect_out(OBS_SEL, "long_shift_sel", 32'(SEL_SAMPLE));
    sb_drain();

    // TRST mid-shift, on the same edge as shift and update, wins over all enables
    load_ir(4'b0000);
    expect_out(OBS_SEL, "pre_trst_sel", 32'(SEL_EXTEST));
    sb_drain();
    select = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 1);
    tick();
    tick();
    TRST = 1'b1;
    drive(1, 1, 1, 1, 1, 1);
    tick();
    TRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    expect_out(OBS_IR, "trst_mid_ir", 32'(RST_IR));
    expect_out(OBS_SEL, "trst_mid_sel", 32'(RST_SEL));
    expect_out(OBS_TDO, "trst_mid_irshift", 32'(1'b0));
    sb_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_ir_decoder.md
JTAG_IR_DECODER -- requirements
Module: jtag_ir_decoder

Interface
REQ-001 SHALL provide parameter IR_WIDTH, default 4: instruction register length in bits, minimum 2.
REQ-002 SHALL provide parameter IDCODE_VALUE, default 32'h1000_0001: device ID, bit 0 is 1.
REQ-003 SHALL use one clock and a synchronous, active-high reset; ports TCK and TRST.
REQ-004 TCK  input  1  scan clock; every register updates on the rising edge only.
REQ-005 TRST  input  1  synchronous active-high reset.
REQ-006 TDI  input  1  serial scan data in.
REQ-007 clockir, shiftir, updateir  input  1 each  TAP IR enables: clockir = capture/shift this edge, shiftir = shift (1) or capture (0), updateir = latch instruction.
REQ-008 clockdr, shiftdr  input  1 each  TAP DR enables, same meaning as the IR enables.
REQ-009 select  input  1  TDO source: 1 = IR path, 0 = DR path.
REQ-010 bsr_tdo  input  1  serial output of the external boundary-scan chain.
REQ-011 TDO  output  1  serial scan data out.
REQ-012 tdo_en  output  1  high while a shift is active.
REQ-013 ir_out  output  IR_WIDTH  currently latched instruction.
REQ-014 extest_sel, sample_sel, idcode_sel, bypass_sel  output  1 each  one-hot decode of ir_out.

Function
REQ-015 Opcodes SHALL be EXTEST=0, SAMPLE=1, IDCODE=2, BYPASS=all-ones; any other code SHALL decode as BYPASS.
REQ-016 IR capture: clockir=1, shiftir=0 SHALL load ir_shift with 1 in bit 0 and 0 in all other bits (the "...01" pattern).
REQ-017 IR shift: clockir=1, shiftir=1 SHALL load ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]}.
REQ-018 clockir=0 SHALL hold ir_shift, whatever the value of shiftir.
REQ-019 updateir=1 SHALL load ir_out from ir_shift and register the one-hot decode on the same edge; latency from updateir edge to new selects is 0 cycles (outputs valid after that edge).
REQ-020 updateir together with clockir SHALL latch the pre-edge ir_shift value.
REQ-021 Bypass register: clockdr=1, shiftdr=0 SHALL load 0; clockdr=1, shiftdr=1 SHALL load TDI; otherwise hold.
REQ-022 IDCODE register (32 bits): capture SHALL load IDCODE_VALUE; shift SHALL load {TDI, id[31:1]}; it SHALL be clocked only while idcode_sel=1.
REQ-023 TDO SHALL be combinational:
- select=1: ir_shift[0]
- select=0 with extest_sel or sample_sel: bsr_tdo
- select=0 with idcode_sel: id[0]
- select=0 with bypass_sel: bypass bit
REQ-024 tdo_en SHALL equal (clockir&shiftir)|(clockdr&shiftdr).
REQ-025 Exactly one of the four selects SHALL be high at all times.
REQ-026 A shift longer than IR_WIDTH SHALL keep only the last IR_WIDTH TDI bits; there is no overflow flag.

Reset
REQ-027 TRST=1 SHALL set ir_shift=0, bypass=0, id=IDCODE_VALUE, and ir_out to IDCODE (with JTAG_IDCODE_EN) or BYPASS (without), with the matching select high.
REQ-028 TRST SHALL take priority over every enable on the same edge, including mid-shift; a partial shift SHALL be discarded.

Configuration
REQ-029 Macro JTAG_IDCODE_EN defined: the IDCODE register and opcode SHALL be present, and reset instruction = IDCODE.
REQ-030 Macro JTAG_IDCODE_EN undefined: no IDCODE register SHALL exist; opcode 2 SHALL decode as BYPASS; idcode_sel SHALL tie to 0; reset instruction = BYPASS.

Structure
REQ-031 Package jtag_pkg SHALL hold the opcode constants, the default IR_WIDTH and the default IDCODE_VALUE.
REQ-032 The IDCODE register SHALL be a sub-module jtag_id_reg with ports TCK, TRST, TDI, capture, shift and tdo.

Verification
REQ-033 TRST=1 for 1 cycle -> ir_out=4'b0010, idcode_sel=1 (macro on); ir_out=4'b1111, bypass_sel=1 (macro off).
REQ-034 IR capture then 4 shifts of TDI=0,0,0,0, then updateir -> TDO during the shift = 1,0,0,0; ir_out=0; extest_sel=1; TDO follows bsr_tdo with select=0.
REQ-035 Load BYPASS, DR capture, shift TDI=1,0,1 -> TDO = 0,1,0 (1-cycle delay).
REQ-036 Load IDCODE, DR capture, 32 shifts -> TDO sequence = IDCODE_VALUE, LSB first.
REQ-037 Load opcode 4'b0101 -> bypass_sel=1, other selects 0.
REQ-038 TRST asserted after 2 of 4 IR shifts, then updateir -> ir_out = reset instruction, ir_shift=0.
